// File: rtl/fpadd_stream_ctrl.sv
// fpadd_stream_ctrl
//   Streaming wrapper around a free-running pipelined FP16 adder. It accepts
//   operand pairs over valid/ready and registers them onto the adder inputs.
//   A valid delay line follows each operation through the adder, and a
//   first-word-fall-through FIFO catches the results. The input is credit
//   gated: ready is only offered while the FIFO entries plus the operations
//   still in the adder stay below DEPTH, so no result can ever be dropped.
//   This block does no arithmetic. Results pass through bit-exact.
//
// Ports
//   clk_59, rst_59           clock, synchronous active-high reset
//   in_valid_59/in_ready_59  operand handshake, in_a_59/in_b_59 operands
//   add_a_59/add_b_59        registered operands to the adder
//   add_c_59                 adder result, valid LAT edges after the operands launch
//   out_valid_59/out_ready_59/out_data_59  result stream (FIFO head)
//   inflight_59              operations issued but not yet captured
module fpadd_stream_ctrl #(
   parameter int W     = 16,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk_59,
   input  logic                       rst_59,
   input  logic                       in_valid_59,
   output logic                       in_ready_59,
   input  logic [W-1:0]               in_a_59,
   input  logic [W-1:0]               in_b_59,
   output logic [W-1:0]               add_a_59,
   output logic [W-1:0]               add_b_59,
   input  logic [W-1:0]               add_c_59,
   output logic                       out_valid_59,
   input  logic                       out_ready_59,
   output logic [W-1:0]               out_data_59,
   output logic [$clog2(LAT+1)-1:0]   inflight_59
);

   localparam int IW = $clog2(LAT+1);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   logic [W-1:0]   r_add_a;
   logic [W-1:0]   r_add_b;
   // r_vld[k-1] marks an operation that entered the adder k edges ago
   logic [LAT-1:0] r_vld;
   logic [W-1:0]   r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic           w_accept;
   logic           w_push;
   logic           w_pop;
   logic           w_in_ready;
   logic           w_not_empty;
   logic [IW-1:0]  w_inflight;
   logic [SW-1:0]  w_credit_sum;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + IW'(r_vld[i]);
      end
   end

   // Credit comes from registers only, so a pop raises ready one cycle later.
   assign w_credit_sum = SW'(r_count) + SW'(w_inflight);
   assign w_in_ready   = w_credit_sum < SW'(DEPTH);
   assign w_not_empty  = r_count != '0;
   assign w_accept     = in_valid_59 && w_in_ready;
   // The oldest tracked operation has its result on add_c_59 this cycle.
   assign w_push       = r_vld[LAT-1];
   assign w_pop        = w_not_empty && out_ready_59;

   always_ff @(posedge clk_59) begin
      if (rst_59) begin
         r_add_a <= '0;
         r_add_b <= '0;
         r_vld   <= '0;
      end else begin
         if (w_accept) begin
            r_add_a <= in_a_59;
            r_add_b <= in_b_59;
         end
         r_vld[0] <= w_accept;
         for (int k = 1; k < LAT; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   always_ff @(posedge clk_59) begin
      if (rst_59) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_59) begin
      if (w_push) r_mem[r_wr_ptr] <= add_c_59;
   end

   assign in_ready_59  = w_in_ready;
   assign add_a_59     = r_add_a;
   assign add_b_59     = r_add_b;
   assign out_valid_59 = w_not_empty;
   assign out_data_59  = w_not_empty ? r_mem[r_rd_ptr] : '0;
   assign inflight_59  = w_inflight;

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Bench for fpadd_stream_ctrl. A behavioural adder pipeline answers from a
// table of hand-computed FP16 sums. Expected results are queued when an
// operand pair is accepted, and a monitor compares them on every output
// transfer.
module tb_fpadd_stream_ctrl;
   localparam int W     = 16;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] add_a, add_b, add_c;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   inflight;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   fpadd_stream_ctrl #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk_59(clk), .rst_59(rst),
      .in_valid_59(in_valid), .in_ready_59(in_ready),
      .in_a_59(in_a), .in_b_59(in_b),
      .add_a_59(add_a), .add_b_59(add_b), .add_c_59(add_c),
      .out_valid_59(out_valid), .out_ready_59(out_ready),
      .out_data_59(out_data), .inflight_59(inflight)
   );

   function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
      case ({a, b})
         32'h5620_5948: return 16'h5C2C;
         32'h5630_D590: return 16'h4900;
         32'hD1A0_54F0: return 16'h5040;
         32'hDC6C_D420: return 16'hDD74;
         default:       return (a == 16'h0000) ? b : 16'hFFFF;
      endcase
   endfunction

   // Adder model: operand register (inside the DUT) plus LAT-1 stages here.
   logic [W-1:0] s_pipe [LAT-1];
   always @(posedge clk) begin
      s_pipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < LAT-1; i++) s_pipe[i] <= s_pipe[i-1];
   end
   assign add_c = s_pipe[LAT-2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_data), 32'hDEAD_0000);
         end else begin
            chk("result_order", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && dut.w_push && dut.r_count == 3'(DEPTH)) begin
         $display("FAIL fifo_overflow: push with count %0d required below %0d", dut.r_count, DEPTH);
         $fatal(1, "overflow");
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL global_timeout: run did not finish, required completion");
      $fatal(1, "timeout");
   end

   // Present a pair and hold it until accepted; leaves in_valid high so
   // consecutive calls issue on consecutive cycles.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, output int waited);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      waited = 0;
      while (waited < 200) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            @(posedge clk); #1;
            return;
         end
         waited++;
         @(posedge clk); #1;
      end
      chk("accept_timeout", 32'(waited), 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Negedges from return of send() until out_valid is seen.
   task automatic latency(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      chk(name, 32'(n), 32'd4);
   endtask

   initial begin
      int w;
      int seen;
      logic [W-1:0] bp_b [6];
      bp_b = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_inflight",  32'(inflight),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_add_a",     32'(add_a),     32'd0);
      chk("rst_add_b",     32'(add_b),     32'd0);
      @(posedge clk); #1;

      // single op
      out_ready = 1'b1;
      send(16'h5620, 16'h5948, 16'h5C2C, w);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("single_inflight", 32'(inflight), 32'd1);
         chk("single_not_early", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk("single_inflight_done", 32'(inflight), 32'd0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'h5C2C);
      drain("single_drain");

      // back-to-back stream
      seen = 0;
      send(16'h5630, 16'hD590, 16'h4900, w); seen += w;
      send(16'hD1A0, 16'h54F0, 16'h5040, w); seen += w;
      send(16'hDC6C, 16'hD420, 16'hDD74, w); seen += w;
      in_valid = 1'b0;
      chk("stream_no_stall", 32'(seen), 32'd0);
      @(negedge clk);
      chk("stream_gap_before", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stream_consecutive", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      chk("stream_gap_after", 32'(out_valid), 32'd0);
      drain("stream_drain");

      // backpressure
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(16'h0000, bp_b[i], bp_b[i], w);
         chk("bp_accept_immediate", 32'(w), 32'd0);
      end
      in_a = 16'h0000;
      in_b = bp_b[4];
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (in_ready) seen++;
         @(posedge clk); #1;
      end
      chk("bp_ready_low", 32'(seen), 32'd0);
      chk("bp_held_count", 32'(exp_q.size()), 32'd4);
      out_ready = 1'b1;
      send(16'h0000, bp_b[4], bp_b[4], w);
      send(16'h0000, bp_b[5], bp_b[5], w);
      in_valid = 1'b0;
      drain("bp_drain");

      // full FIFO with simultaneous push and pop
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(16'h0000, 16'h4800, 16'h4800, w);
      send(16'h0000, 16'h4900, 16'h4900, w);
      send(16'h0000, 16'h4A00, 16'h4A00, w);
      send(16'h0000, 16'h4B00, 16'h4B00, w);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("full_pre_inflight", 32'(inflight), 32'd1);
      chk("full_pre_ready", 32'(in_ready), 32'd0);
      chk("full_pre_head", 32'(out_data), 32'h4800);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("full_pushpop_inflight", 32'(inflight), 32'd0);
      chk("full_pushpop_ready", 32'(in_ready), 32'd1);
      chk("full_pushpop_head", 32'(out_data), 32'h4900);
      drain("full_drain");

      // zero and identity
      send(16'h0000, 16'h0000, 16'h0000, w);
      in_valid = 1'b0;
      latency("zero_latency");
      drain("zero_drain");
      send(16'h0000, 16'hD750, 16'hD750, w);
      in_valid = 1'b0;
      latency("ident_latency");
      chk("ident_data", 32'(out_data), 32'hD750);
      drain("ident_drain");

      // reset with operations in flight
      send(16'h5620, 16'h5948, 16'h5C2C, w);
      send(16'h5630, 16'hD590, 16'h4900, w);
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_inflight", 32'(inflight), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst_mid_no_stale", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fpadd_stream_ctrl.md
Name: fpadd_stream_ctrl

Overview:
- Streaming front/back-end wrapper for the pipelined half-precision adder (`fpadder`).
- Accepts operand pairs over a valid/ready handshake and drives registered operands into the adder.
- Tracks in-flight operations with a valid delay line matching the adder latency.
- Captures each result into an output FIFO with valid/ready.
- Credit logic guarantees no result is ever dropped under backpressure.

Parameters:
- W, 16, operand/result width (FP16).
- LAT, 3, adder latency: rising edges from operands present on add_a_59/add_b_59 to the valid result on add_c_59.
- DEPTH, 4, output FIFO depth in entries (power of two, >= 2).

Ports:
- clk_59  in  1  single clock, rising edge.
- rst_59  in  1  reset, synchronous, active-high.
- in_valid_59  in  1  operand pair valid.
- in_ready_59  out  1  block can accept an operand pair.
- in_a_59  in  W  operand A.
- in_b_59  in  W  operand B.
- add_a_59  out  W  registered operand A to adder port A_59.
- add_b_59  out  W  registered operand B to adder port B_59.
- add_c_59  in  W  adder result C_59.
- out_valid_59  out  1  result available at FIFO head.
- out_ready_59  in  1  consumer accepts result.
- out_data_59  out  W  FIFO head result.
- inflight_59  out  clog2(LAT+1)  operations issued but not yet captured.

Behaviour:
- Clock and reset: one clock, clk_59. rst_59 is synchronous and active-high: it is sampled on the rising edge of clk_59 and takes priority over all other activity.
- Reset values:
  - add_a_59 = add_b_59 = 0.
  - Valid delay line vld[1..LAT] = 0.
  - FIFO empty: pointers 0, count 0.
  - out_valid_59 = 0; out_data_59 = 0 while empty.
  - inflight_59 = 0.
  - in_ready_59 = 1 in the first cycle after reset deasserts.
- Accept: occurs at a rising edge when in_valid_59 && in_ready_59.
  - On accept: add_a_59 <= in_a_59, add_b_59 <= in_b_59, vld[1] <= 1.
  - Without accept: add_a_59/add_b_59 hold their values, vld[1] <= 0. The adder is free-running; its untracked outputs are ignored.
- Delay line: every edge, vld[k+1] <= vld[k]. When vld[LAT] = 1, add_c_59 holds that operation's result and is pushed into the FIFO at the next edge.
- Latency: accept at edge E0 -> push at edge E0+LAT -> out_valid_59 = 1 and out_data_59 = result in the cycle after E0+LAT. With LAT=3, the result is visible 3 cycles after the accepting edge.
- inflight_59 = popcount(vld[1..LAT]).
- Credit: in_ready_59 = (fifo_count + inflight_59) < DEPTH.
  - Combinational from registers only; it does not depend on in_valid_59 or out_ready_59.
  - A pop in the current cycle does not raise ready until the next cycle.
- FIFO: first-word-fall-through.
  - Pop at an edge when out_valid_59 && out_ready_59.
  - Simultaneous push and pop at the same edge: count unchanged, data order preserved.
  - Push when full cannot occur by construction. The bench asserts this as a fatal check.
  - Pointers wrap modulo DEPTH.
  - Results emerge in strict issue order.
- Backpressure: with out_ready_59 = 0 held, exactly DEPTH operations are accepted; then in_ready_59 stays 0 until a pop.
- Throughput: one accept per cycle while credit is available.
- Reset mid-operation: all tracked in-flight operations and buffered results are discarded. Results still emerging from the adder pipeline are not captured because vld is cleared. No output is produced for them.
- No arithmetic is performed in this block. Results pass through bit-exact.

Test Plan:
- Single op: A=5620, B=5948, LAT=3, accept at edge 0 -> out_valid_59 rises after edge 3 with out_data_59 = 5C2C; inflight_59 reads 1, 1, 1, then 0.
- Back-to-back stream, out_ready_59 = 1: pairs (5630,D590), (D1A0,54F0), (DC6C,D420) on consecutive cycles -> outputs 4900, 5040, DD74 on consecutive cycles, in order; in_ready_59 stays 1.
- Backpressure: out_ready_59 = 0, in_valid_59 held with six pairs -> exactly 4 accepted and in_ready_59 = 0 afterwards. Then release out_ready_59 -> 4 results in order, the remaining 2 are accepted as credit frees, and nothing is lost or duplicated.
- Full with simultaneous push/pop: FIFO at 3 entries with 1 in flight, out_ready_59 = 1 on the push edge -> count stays 3, head advances, and no overflow assertion fires.
- Zero and identity: (0000,0000) -> 0000; (0000,D750) -> D750, each with correct latency.
- Reset mid-flight: issue 2 ops, assert rst_59 for 1 edge at edge 1 -> out_valid_59 = 0, inflight_59 = 0, in_ready_59 = 1, and no stale result appears in the following 10 cycles.
